// File: rtl/rsa_probe_pkg.sv
// Shared types and default parameters for the RSA decrypt timing probe.
package rsa_probe_pkg;

  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned REP_W_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    GAP,
    REPORT
  } state_e;

endpackage

// File: rtl/rsa_probe_stats.sv
// Latency statistics accumulator: min/max/saturating total plus result consistency.
module rsa_probe_stats
  import rsa_probe_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned REP_W = REP_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   update_i,
  input  logic [CNT_W-1:0]       lat_i,
  input  logic [WIDTH-1:0]       m_i,
  output logic [CNT_W-1:0]       min_o,
  output logic [CNT_W-1:0]       max_o,
  output logic [CNT_W+REP_W-1:0] total_o,
  output logic [WIDTH-1:0]       m_o,
  output logic                   mismatch_o
);

  localparam int unsigned TOT_W = CNT_W + REP_W;

  logic [CNT_W-1:0] min_q, max_q;
  logic [TOT_W-1:0] total_q;
  logic [WIDTH-1:0] m_q;
  logic             mismatch_q;
  logic             seen_q;
  logic [TOT_W:0]   sum_c;

  // One extra bit catches the carry so the total can clamp at all ones.
  assign sum_c = {1'b0, total_q} + (TOT_W+1)'(lat_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q      <= '1;
      max_q      <= '0;
      total_q    <= '0;
      m_q        <= '0;
      mismatch_q <= 1'b0;
      seen_q     <= 1'b0;
    end else if (clear_i) begin
      min_q      <= '1;
      max_q      <= '0;
      total_q    <= '0;
      m_q        <= '0;
      mismatch_q <= 1'b0;
      seen_q     <= 1'b0;
    end else if (update_i) begin
      if (lat_i < min_q) min_q <= lat_i;
      if (lat_i > max_q) max_q <= lat_i;
      total_q <= sum_c[TOT_W] ? '1 : sum_c[TOT_W-1:0];
      if (!seen_q) begin
        m_q    <= m_i;
        seen_q <= 1'b1;
      end else if (m_i != m_q) begin
        mismatch_q <= 1'b1;
      end
    end
  end

  assign min_o      = min_q;
  assign max_o      = max_q;
  assign total_o    = total_q;
  assign m_o        = m_q;
  assign mismatch_o = mismatch_q;

endmodule

// File: rtl/rsa_timing_probe.sv
// Drives repeated start/finish handshakes on the decrypt core and reports latency stats.
module rsa_timing_probe
  import rsa_probe_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned REP_W   = REP_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [WIDTH-1:0]       cmd_c_i,
  input  logic [REP_W-1:0]       cmd_reps_i,
  output logic                   tgt_start_o,
  output logic [WIDTH-1:0]       tgt_c_o,
  input  logic                   tgt_finish_i,
  input  logic [WIDTH-1:0]       tgt_m_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [CNT_W-1:0]       res_min_o,
  output logic [CNT_W-1:0]       res_max_o,
  output logic [CNT_W+REP_W-1:0] res_total_o,
  output logic [WIDTH-1:0]       res_m_o,
  output logic                   res_mismatch_o,
  output logic                   res_timeout_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] reps_left_q, reps_left_d;
  logic [WIDTH-1:0] tgt_c_q, tgt_c_d;
  logic             tgt_start_q, tgt_start_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             timeout_q, timeout_d;
  logic             stats_clear_c, stats_update_c;
  logic [CNT_W-1:0] lat_c;

  assign lat_c = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reps_left_q <= '0;
      tgt_c_q     <= '0;
      tgt_start_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reps_left_q <= reps_left_d;
      tgt_c_q     <= tgt_c_d;
      tgt_start_q <= tgt_start_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    reps_left_d    = reps_left_q;
    tgt_c_d        = tgt_c_q;
    tgt_start_d    = 1'b0;
    res_valid_d    = res_valid_q;
    timeout_d      = timeout_q;
    stats_clear_c  = 1'b0;
    stats_update_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          tgt_c_d       = cmd_c_i;
          reps_left_d   = (cmd_reps_i == '0) ? REP_W'(1) : cmd_reps_i;
          timeout_d     = 1'b0;
          stats_clear_c = 1'b1;
          tgt_start_d   = 1'b1;
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (tgt_finish_i) begin
          stats_update_c = 1'b1;
          reps_left_d    = reps_left_q - REP_W'(1);
          if (reps_left_q == REP_W'(1)) begin
            res_valid_d = 1'b1;
            state_d     = REPORT;
          end else begin
            state_d = GAP;
          end
        end else if (lat_c == CNT_W'(TIMEOUT)) begin
          timeout_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = REPORT;
        end else begin
          cnt_d = lat_c;
        end
      end
      GAP: begin
        // A level-style finish must drop before the core is relaunched.
        if (!tgt_finish_i) begin
          tgt_start_d = 1'b1;
          state_d     = LAUNCH;
        end
      end
      REPORT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  rsa_probe_stats #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .REP_W (REP_W)
  ) u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (stats_clear_c),
    .update_i   (stats_update_c),
    .lat_i      (lat_c),
    .m_i        (tgt_m_i),
    .min_o      (res_min_o),
    .max_o      (res_max_o),
    .total_o    (res_total_o),
    .m_o        (res_m_o),
    .mismatch_o (res_mismatch_o)
  );

  assign cmd_ready_o   = cmd_ready_q;
  assign tgt_start_o   = tgt_start_q;
  assign tgt_c_o       = tgt_c_q;
  assign res_valid_o   = res_valid_q;
  assign res_timeout_o = timeout_q;

endmodule

// File: tb/tb_rsa_timing_probe.sv
// Scoreboard bench for rsa_timing_probe with a configurable stub decrypt core.
module tb_rsa_timing_probe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_c = 8'h00;
  logic [7:0]  cmd_reps = 8'h00;
  logic        tgt_start;
  logic [7:0]  tgt_c;
  logic        tgt_finish;
  logic [7:0]  tgt_m;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_min;
  logic [15:0] res_max;
  logic [23:0] res_total;
  logic [7:0]  res_m;
  logic        res_mismatch;
  logic        res_timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rsa_timing_probe #(.TIMEOUT(20)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_c_i        (cmd_c),
    .cmd_reps_i     (cmd_reps),
    .tgt_start_o    (tgt_start),
    .tgt_c_o        (tgt_c),
    .tgt_finish_i   (tgt_finish),
    .tgt_m_i        (tgt_m),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_min_o      (res_min),
    .res_max_o      (res_max),
    .res_total_o    (res_total),
    .res_m_o        (res_m),
    .res_mismatch_o (res_mismatch),
    .res_timeout_o  (res_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Stub core: per-run latency (0 = never finishes), result and finish hold length.
  logic [15:0] lat_tab [4];
  logic [7:0]  m_tab [4];
  int          hold = 1;
  logic        busy;
  logic [15:0] scnt, lat_cur;
  logic [7:0]  m_cur;
  int          run_idx;
  int          viol = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; scnt <= '0; lat_cur <= '0; m_cur <= '0; run_idx <= 0;
    end else begin
      if (tgt_start && tgt_finish) viol <= viol + 1;
      if (cmd_valid && cmd_ready) run_idx <= 0;
      if (tgt_start) begin
        busy    <= 1'b1;
        scnt    <= 16'd1;
        lat_cur <= lat_tab[run_idx % 4];
        m_cur   <= m_tab[run_idx % 4];
        run_idx <= run_idx + 1;
      end else if (busy && scnt < 16'hFFF0) begin
        scnt <= scnt + 16'd1;
      end
    end
  end

  assign tgt_finish = busy && (lat_cur != 16'd0) && (scnt >= lat_cur) && (scnt < lat_cur + 16'(hold));
  assign tgt_m = m_cur;

  // Cycle bookkeeping for accept-to-result latency.
  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
  end

  typedef struct {
    logic [7:0]  c;
    logic [15:0] mn, mx;
    logic [23:0] tot;
    logic [7:0]  m;
    logic        chk_m;
    logic        mis, tmo;
    int          starts;
    int          delay;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic [7:0] c, input logic [15:0] mn, input logic [15:0] mx,
                      input logic [23:0] tot, input logic [7:0] m, input logic chk_m,
                      input logic mis, input logic tmo, input int starts, input int delay);
    exp_t e;
    e.c = c; e.mn = mn; e.mx = mx; e.tot = tot; e.m = m; e.chk_m = chk_m;
    e.mis = mis; e.tmo = tmo; e.starts = starts; e.delay = delay;
    sb.push_back(e);
  endtask

  // Monitor: compares each consumed result against the oldest expectation.
  int   rv_delay = 0;
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (res_valid && !rv_prev) rv_delay = cyc - acc_cyc - 1;
    rv_prev = res_valid;
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        check("res_min", 32'(res_min), 32'(e.mn));
        check("res_max", 32'(res_max), 32'(e.mx));
        check("res_total", 32'(res_total), 32'(e.tot));
        if (e.chk_m) check("res_m", 32'(res_m), 32'(e.m));
        check("res_mismatch", 32'(res_mismatch), 32'(e.mis));
        check("res_timeout", 32'(res_timeout), 32'(e.tmo));
        check("tgt_c_held", 32'(tgt_c), 32'(e.c));
        check("start_count", 32'(run_idx), 32'(e.starts));
        if (e.delay >= 0) check("result_delay", 32'(rv_delay), 32'(e.delay));
      end
    end
  end

  task automatic set_stub(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2,
                          input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2, input int h);
    lat_tab[0] = l0; lat_tab[1] = l1; lat_tab[2] = l2; lat_tab[3] = l2;
    m_tab[0] = m0; m_tab[1] = m1; m_tab[2] = m2; m_tab[3] = m2;
    hold = h;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] reps);
    @(posedge clk); #1;
    cmd_c = c; cmd_reps = reps; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready && !res_valid) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=busy expected=idle", name);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_tgt_start"}, 32'(tgt_start), 32'd0);
    check({tag, "_tgt_c"}, 32'(tgt_c), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_min"}, 32'(res_min), 32'h0000FFFF);
    check({tag, "_res_max"}, 32'(res_max), 32'd0);
    check({tag, "_res_total"}, 32'(res_total), 32'd0);
    check({tag, "_res_m"}, 32'(res_m), 32'd0);
    check({tag, "_res_flags"}, 32'({res_mismatch, res_timeout}), 32'd0);
  endtask

  initial begin
    logic [63:0] snap;
    bit          stable;
    bit          got;

    set_stub(16'd5, 16'd5, 16'd5, 8'h2A, 8'h2A, 8'h2A, 1);
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fixed latency 5, pulse finish.
    push(8'h11, 16'd5, 16'd5, 24'd15, 8'h2A, 1'b1, 1'b0, 1'b0, 3, -1);
    send(8'h11, 8'd3);
    wait_idle("t_fixed");

    // Level finish held 3 cycles with varying latency.
    set_stub(16'd4, 16'd9, 16'd6, 8'h2A, 8'h2A, 8'h2A, 3);
    push(8'h22, 16'd4, 16'd9, 24'd19, 8'h2A, 1'b1, 1'b0, 1'b0, 3, -1);
    send(8'h22, 8'd3);
    wait_idle("t_level");
    check("no_relaunch_during_finish", 32'(viol), 32'd0);

    // Zero repetitions behave as one run.
    set_stub(16'd7, 16'd7, 16'd7, 8'h2A, 8'h2A, 8'h2A, 1);
    push(8'h33, 16'd7, 16'd7, 24'd7, 8'h2A, 1'b1, 1'b0, 1'b0, 1, -1);
    send(8'h33, 8'd0);
    wait_idle("t_reps0");

    // Core never finishes: timeout after 20 waited cycles.
    set_stub(16'd0, 16'd0, 16'd0, 8'h00, 8'h00, 8'h00, 1);
    push(8'h44, 16'hFFFF, 16'd0, 24'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 21);
    send(8'h44, 8'd2);
    wait_idle("t_timeout");

    // Second run returns a different message.
    set_stub(16'd3, 16'd3, 16'd3, 8'h2A, 8'h2B, 8'h2B, 1);
    push(8'h55, 16'd3, 16'd3, 24'd6, 8'h2A, 1'b1, 1'b1, 1'b0, 2, -1);
    send(8'h55, 8'd2);
    wait_idle("t_mismatch");

    // Host stalls the result for 10 cycles.
    set_stub(16'd2, 16'd2, 16'd2, 8'h55, 8'h55, 8'h55, 1);
    push(8'h66, 16'd2, 16'd2, 24'd2, 8'h55, 1'b1, 1'b0, 1'b0, 1, -1);
    @(posedge clk); #1;
    res_ready = 1'b0;
    send(8'h66, 8'd1);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1;
    end
    check("stall_res_valid_seen", 32'(got), 32'd1);
    snap = {res_min, res_max, res_total, res_m, res_mismatch, res_timeout, 6'd0};
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({res_min, res_max, res_total, res_m, res_mismatch, res_timeout, 6'd0} !== snap ||
          cmd_ready || !res_valid) stable = 0;
    end
    check("stall_stable", 32'(stable), 32'd1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle("t_stall");

    // Reset during the second run aborts everything.
    set_stub(16'd5, 16'd5, 16'd5, 8'h2A, 8'h2A, 8'h2A, 1);
    send(8'h77, 8'd3);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (run_idx == 2) got = 1;
    end
    check("reset_reached_run2", 32'(got), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Recovery command with minimum latency of one cycle.
    set_stub(16'd1, 16'd1, 16'd1, 8'h3C, 8'h3C, 8'h3C, 1);
    push(8'h88, 16'd1, 16'd1, 24'd2, 8'h3C, 1'b1, 1'b0, 1'b0, 2, -1);
    send(8'h88, 8'd2);
    wait_idle("t_recover");

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsa_timing_probe.md
# rsa_timing_probe

Timing-measurement initiator for the RSA decrypt path. It accepts a ciphertext and a repetition count from a host. It drives the decrypt core's start/finish handshake that many times and counts cycles from each start to each finish. It then returns minimum, maximum and total latency, the decrypted message, and error flags. It sits on the initiator side of the decrypt core's interface, replacing the upstream encrypt stage when the design is run as a side-channel test harness.

## Interface
- WIDTH, 8, message/ciphertext width
- CNT_W, 16, per-run cycle counter width
- REP_W, 8, repetition count width
- TIMEOUT, 16'hFFFF, max cycles waited per run (must be < 2^CNT_W)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  probe idle, command accepted when valid&ready
- cmd_c  in  WIDTH  ciphertext to decrypt
- cmd_reps  in  REP_W  run count; 0 treated as 1
- tgt_start  out  1  one-cycle start pulse to decrypt core
- tgt_c  out  WIDTH  ciphertext to core, held stable for whole command
- tgt_finish  in  1  core done (level or pulse)
- tgt_m  in  WIDTH  core result, valid when tgt_finish=1
- res_valid  out  1  result available
- res_ready  in  1  host consumes result
- res_min  out  CNT_W  smallest run latency
- res_max  out  CNT_W  largest run latency
- res_total  out  CNT_W+REP_W  saturating sum of latencies
- res_m  out  WIDTH  tgt_m captured on first run
- res_mismatch  out  1  a later run returned a tgt_m different from res_m
- res_timeout  out  1  command aborted on timeout

## Operation
- States: IDLE, LAUNCH, WAIT, GAP, REPORT.
- IDLE: cmd_ready=1. On cmd_valid:
  - latch cmd_c into tgt_c and reps (0 -> 1) into reps_left
  - set min = all ones; clear max, total and flags
  - go to LAUNCH
- LAUNCH: tgt_start=1 for exactly this cycle; cnt=0; go to WAIT.
- WAIT: cnt increments every cycle. On the cycle tgt_finish=1, latency L = cnt+1, so finish in the first WAIT cycle gives L=1. Then:
  - min = min(min,L), max = max(max,L)
  - total += L, saturating at all ones
  - first run: res_m = tgt_m; later runs: set mismatch if tgt_m != res_m
  - decrement reps_left; go to REPORT if it reaches 0, else GAP
- Timeout: in WAIT, if cnt+1 == TIMEOUT and tgt_finish=0, set timeout and go to REPORT. The stats hold only the completed runs. If no run completed, min stays all ones.
- GAP: stays until tgt_finish is sampled 0, then goes to LAUNCH. This guarantees a level-style finish is deasserted before relaunch.
- REPORT: res_valid=1 with all res_* stable. On res_ready go to IDLE. Outputs keep their values until the next command is accepted.
- tgt_finish is ignored in IDLE, LAUNCH and REPORT.
- cmd_valid is ignored outside IDLE; no queueing.

## Timing
- Reset values: state IDLE, cmd_ready=1, tgt_start=0, tgt_c=0, res_valid=0, res_min=all ones, res_max=0, res_total=0, res_m=0, res_mismatch=0, res_timeout=0.
- cmd accept edge -> tgt_start high on the next cycle.
- Finish sampled -> either tgt_start again after ≥2 cycles (GAP+LAUNCH), or res_valid on the next cycle.
- res_valid&res_ready in the same cycle as REPORT entry: the result is consumed and cmd_ready=1 on the next cycle.
- Asynchronous reset mid-command aborts immediately, with no pulse or result emitted. The target core must be reset by the same rst_n.
- All outputs are registered; no combinational path from tgt_* to res_*.

## Structure
- Package rsa_probe_pkg holds the state enum (IDLE/LAUNCH/WAIT/GAP/REPORT) and the default width and TIMEOUT constants.
- One sub-module, rsa_probe_stats, holds min/max/saturating-total/mismatch. Its inputs are clear, update, L and m; it is reused for per-bit timing buckets later.
- The FSM, run counter and handshakes stay in the top.

## Test plan
- Stub core with fixed latency 5, finish pulse, tgt_m=8'h2A; cmd_c=8'h11, reps=3 -> min=5, max=5, total=15, res_m=8'h2A, no flags, 3 start pulses.
- Stub latencies 4, 9, 6 with level finish held 3 cycles; reps=3 -> min=4, max=9, total=19. No relaunch occurs while finish is high.
- reps=0, latency 7 -> exactly one run; min=max=total=7.
- Stub never finishes, TIMEOUT=20 -> res_timeout=1, min=16'hFFFF, max=0, total=0, res_valid 21 cycles after accept.
- Stub returns 8'h2A, then 8'h2B on run 2 -> res_m=8'h2A, res_mismatch=1. Separately, hold res_ready=0 for 10 cycles: outputs stable and cmd_ready=0 throughout.
- Assert rst_n=0 during WAIT of run 2 -> all outputs at reset values the same cycle; a new command afterwards completes normally.
